midi_msg_parser: RTL and testbench
==================================

# midi_msg_parser

Byte-level MIDI channel-message parser for the synthesizer control path. It takes received MIDI bytes from the UART receiver and tracks status, running status and data-byte count. It emits one-cycle command strobes with the parameter bytes on `ictrl`/`ictrl_data`. It sits directly upstream of the real-time controller stage (pitch bend) and the voice allocator (note on/off).

## Interface
Parameters:
- `CHANNEL`, default 0, MIDI channel (0–15) accepted when omni mode is not compiled in.

Ports:
- `CLOCK_50`  in  1  system clock.
- `reset_data_N`  in  1  reset: asynchronous, active-low.
- `byte_valid`  in  1  one-cycle strobe; `midi_byte` is valid. Back-to-back strobes are allowed every cycle.
- `midi_byte`  in  8  received MIDI byte.
- `ictrl`  out  8  first data byte (key / controller number / program / bend LSB). Bit 7 is always 0.
- `ictrl_data`  out  8  second data byte (velocity / value / bend MSB); 0 for one-data-byte messages.
- `msg_ch`  out  4  channel of the last emitted message.
- `note_on`  out  1  strobe.
- `note_off`  out  1  strobe.
- `cc_cmd`  out  1  strobe.
- `prog_cmd`  out  1  strobe.
- `pitch_cmd`  out  1  strobe.
- `err_cnt`  out  8  saturating count of discarded orphan data bytes.

## Operation
- Byte classes:
  - Real-time: 0xF8–0xFF.
  - System common: 0xF0–0xF7.
  - Channel status: 0x80–0xEF.
  - Data: 0x00–0x7F.
- Real-time bytes are ignored completely. State, running status and partially collected data are untouched.
- FSM states:
  - IDLE: waiting for a status byte or a running-status data byte.
  - DATA1: waiting for the first data byte.
  - DATA2: waiting for the second data byte.
  - SYSEX.
- Channel status byte, from any state:
  - Latch the status as running status.
  - Discard any partial message.
  - Go to DATA1.
- Data byte in DATA1:
  - Store it as d1.
  - Status 0xCn or 0xDn (one data byte): the message is complete; return to IDLE.
  - Otherwise go to DATA2.
- Data byte in DATA2: store it as d2; the message is complete; go to IDLE.
- Data byte in IDLE:
  - With a valid running status: treat it as d1 and proceed as in DATA1.
  - Without one: it is an orphan; increment `err_cnt` (saturates at 255).
- 0xF0 enters SYSEX and clears running status.
  - Data bytes in SYSEX are discarded without counting.
  - 0xF7 returns to IDLE.
  - Any channel status byte aborts SYSEX.
- 0xF1–0xF6 clear running status and go to IDLE. Their data bytes then count as orphans. A stray 0xF7 outside SYSEX does the same.
- On message completion:
  - `ictrl` = d1.
  - `ictrl_data` = d2 for two-byte messages, 0 for one-byte messages.
  - `msg_ch` = status[3:0].
- Strobe decode:
  - 0x9n with d2 ≠ 0 → `note_on`.
  - 0x9n with d2 = 0 → `note_off`.
  - 0x8n → `note_off`.
  - 0xBn → `cc_cmd`.
  - 0xCn → `prog_cmd`.
  - 0xEn → `pitch_cmd`, with `ictrl` = LSB and `ictrl_data` = MSB.
  - 0xAn and 0xDn are parsed; no strobe, outputs unchanged.
- Channel filter: a completed message whose channel ≠ `CHANNEL` is parsed and consumed, but outputs and strobes are left unchanged.
- At most one strobe is high in any cycle.
- `ictrl`, `ictrl_data` and `msg_ch` hold their value until the next accepted message. The downstream stage samples them across the strobe's trailing edge.

## Timing
- Reset values:
  - `ictrl`, `ictrl_data`, `msg_ch`, `err_cnt` = 0.
  - All strobes = 0.
  - FSM in IDLE, running status invalid.
- Latency:
  - The strobe and the updated `ictrl`/`ictrl_data`/`msg_ch` are registered.
  - They appear on the cycle after the clock edge that samples the final data byte.
  - Strobe width is exactly 1 cycle.
- Output data changes only in the same cycle a strobe rises.
- Reset asserted mid-message: the FSM returns to IDLE immediately and the partial message is lost. The first data byte after reset is an orphan.
- With `byte_valid` low, the state is held indefinitely; there is no timeout.
- `err_cnt` updates on the cycle after the orphan byte.

## Configuration
- `MIDI_OMNI_EN` defined: the channel filter is bypassed, all 16 channels are accepted, and `msg_ch` reports the source channel.
- `MIDI_OMNI_EN` undefined: only `CHANNEL` is accepted, so `msg_ch` always equals `CHANNEL`.

## Test plan
- Pitch bend: E0 00 40 → one `pitch_cmd` pulse, with `ictrl` = 0x00 and `ictrl_data` = 0x40 held afterwards. Downstream bend value = 8192.
- Running status with velocity-0 note-on: 90 3C 64 3E 64 3E 00 → two `note_on` pulses (`ictrl` 0x3C then 0x3E), then `note_off` with `ictrl` = 0x3E and `ictrl_data` = 0.
- Real-time interleave: B0 07 F8 7F at consecutive cycles → one `cc_cmd` with `ictrl` = 0x07 and `ictrl_data` = 0x7F; F8 has no effect.
- Channel filter (CHANNEL = 0, omni off): 91 3C 64 → no strobe and outputs unchanged. Repeat with `MIDI_OMNI_EN` → `note_on` with `msg_ch` = 1.
- SysEx and orphans: F0 7E 01 F7 3C 64 → no strobe and `err_cnt` = 2. Then C0 05 → `prog_cmd` with `ictrl` = 0x05 and `ictrl_data` = 0.
- Mid-message abort: 90 3C, then B0 01 02 → only `cc_cmd` (`ictrl` = 0x01, `ictrl_data` = 0x02). Asserting reset between E0 and 00 → no strobe, and the next 00 40 counts as orphans (`err_cnt` = 2).

Source files
------------

// File: rtl/midi_msg_parser_if.sv
// MIDI parser bus: received-byte strobe in, parsed command strobes and parameters out.
// The master side feeds bytes, and the slave side (the parser) drives the results.
// The bus has no backpressure, so a byte may be offered on every cycle.
interface midi_msg_parser_if;
  logic       byte_valid;
  logic [7:0] midi_byte;
  logic [7:0] ictrl;
  logic [7:0] ictrl_data;
  logic [3:0] msg_ch;
  logic       note_on;
  logic       note_off;
  logic       cc_cmd;
  logic       prog_cmd;
  logic       pitch_cmd;
  logic [7:0] err_cnt;

  modport master (
    output byte_valid, midi_byte,
    input  ictrl, ictrl_data, msg_ch, note_on, note_off, cc_cmd, prog_cmd, pitch_cmd, err_cnt
  );

  modport slave (
    input  byte_valid, midi_byte,
    output ictrl, ictrl_data, msg_ch, note_on, note_off, cc_cmd, prog_cmd, pitch_cmd, err_cnt
  );
endinterface

// File: rtl/midi_msg_parser.sv
// MIDI channel-message parser: status/running-status tracking, one-cycle command strobes.
// Latency: strobe and parameters are registered, one cycle after the final data byte is sampled.
// No backpressure, so a byte is accepted every cycle; define MIDI_OMNI_EN to accept all 16 channels.
module midi_msg_parser #(
  parameter int CHANNEL = 0
) (
  input  logic           CLOCK_50,
  input  logic           reset_data_N,
  midi_msg_parser_if.slave midi
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DATA1 = 2'd1;
  localparam logic [1:0] DATA2 = 2'd2;
  localparam logic [1:0] SYSEX = 2'd3;

`ifndef MIDI_OMNI_EN
  localparam logic [3:0] CH_SEL = CHANNEL[3:0];
`endif

  logic [1:0] state, state_nxt;
  logic [7:0] run_status, run_status_nxt;
  logic       rs_valid, rs_valid_nxt;
  logic [6:0] d1, d1_nxt;

  logic       msg_done;
  logic [6:0] done_d1, done_d2;
  logic       orphan;

  logic       is_rt, is_sys, is_status, one_byte, ch_ok;
  logic       on_nxt, off_nxt, cc_nxt, prog_nxt, pitch_nxt, any_stb;

  // Byte classification and message length of the current running status.
  always_comb begin
    is_rt     = midi.midi_byte[7:3] == 5'b11111;
    is_sys    = midi.midi_byte[7:4] == 4'hF;
    is_status = midi.midi_byte[7];
    // 0xCn and 0xDn carry a single data byte.
    one_byte  = run_status[7:5] == 3'b110;
  end

  // Parser next state: status handling, data collection, message completion, orphan detection.
  always_comb begin
    state_nxt      = state;
    run_status_nxt = run_status;
    rs_valid_nxt   = rs_valid;
    d1_nxt         = d1;
    msg_done       = 1'b0;
    done_d1        = d1;
    done_d2        = 7'd0;
    orphan         = 1'b0;
    if (midi.byte_valid && !is_rt) begin
      if (midi.midi_byte == 8'hF0) begin
        state_nxt    = SYSEX;
        rs_valid_nxt = 1'b0;
      end else if (is_sys) begin
        // F1..F7 (including EOX, stray or not) cancel running status.
        state_nxt    = IDLE;
        rs_valid_nxt = 1'b0;
      end else if (is_status) begin
        run_status_nxt = midi.midi_byte;
        rs_valid_nxt   = 1'b1;
        state_nxt      = DATA1;
      end else begin
        case (state)
          SYSEX: ;
          DATA2: begin
            msg_done  = 1'b1;
            done_d1   = d1;
            done_d2   = midi.midi_byte[6:0];
            state_nxt = IDLE;
          end
          default: begin
            // DATA1 always has a valid status; IDLE needs running status.
            if (state == DATA1 || rs_valid) begin
              d1_nxt = midi.midi_byte[6:0];
              if (one_byte) begin
                msg_done  = 1'b1;
                done_d1   = midi.midi_byte[6:0];
                state_nxt = IDLE;
              end else begin
                state_nxt = DATA2;
              end
            end else begin
              orphan = 1'b1;
            end
          end
        endcase
      end
    end
  end

  // Command decode of a completed message, gated by the channel filter.
  always_comb begin
`ifdef MIDI_OMNI_EN
    ch_ok = 1'b1;
`else
    ch_ok = run_status[3:0] == CH_SEL;
`endif
    on_nxt    = 1'b0;
    off_nxt   = 1'b0;
    cc_nxt    = 1'b0;
    prog_nxt  = 1'b0;
    pitch_nxt = 1'b0;
    if (msg_done && ch_ok) begin
      case (run_status[7:4])
        4'h8: off_nxt   = 1'b1;
        4'h9: begin
          on_nxt  = done_d2 != 7'd0;
          off_nxt = done_d2 == 7'd0;
        end
        4'hB: cc_nxt    = 1'b1;
        4'hC: prog_nxt  = 1'b1;
        4'hE: pitch_nxt = 1'b1;
        default: ;
      endcase
    end
    any_stb = on_nxt | off_nxt | cc_nxt | prog_nxt | pitch_nxt;
  end

  // Parser state registers.
  always_ff @(posedge CLOCK_50 or negedge reset_data_N) begin
    if (!reset_data_N) begin
      state      <= IDLE;
      run_status <= 8'h00;
      rs_valid   <= 1'b0;
      d1         <= 7'd0;
    end else begin
      state      <= state_nxt;
      run_status <= run_status_nxt;
      rs_valid   <= rs_valid_nxt;
      d1         <= d1_nxt;
    end
  end

  // Registered strobes and held parameters; parameters move only with a strobe.
  always_ff @(posedge CLOCK_50 or negedge reset_data_N) begin
    if (!reset_data_N) begin
      midi.note_on    <= 1'b0;
      midi.note_off   <= 1'b0;
      midi.cc_cmd     <= 1'b0;
      midi.prog_cmd   <= 1'b0;
      midi.pitch_cmd  <= 1'b0;
      midi.ictrl      <= 8'h00;
      midi.ictrl_data <= 8'h00;
      midi.msg_ch     <= 4'h0;
    end else begin
      midi.note_on   <= on_nxt;
      midi.note_off  <= off_nxt;
      midi.cc_cmd    <= cc_nxt;
      midi.prog_cmd  <= prog_nxt;
      midi.pitch_cmd <= pitch_nxt;
      if (any_stb) begin
        midi.ictrl      <= {1'b0, done_d1};
        midi.ictrl_data <= {1'b0, done_d2};
        midi.msg_ch     <= run_status[3:0];
      end
    end
  end

  // Saturating orphan counter.
  always_ff @(posedge CLOCK_50 or negedge reset_data_N) begin
    if (!reset_data_N) begin
      midi.err_cnt <= 8'h00;
    end else if (orphan && midi.err_cnt != 8'hFF) begin
      midi.err_cnt <= midi.err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_midi_msg_parser.sv
// Bench for midi_msg_parser: directed test-plan sequences, then random byte streams.
// Each cycle's outputs are compared against a queue-based message model.
module tb_midi_msg_parser;
  localparam int CH = 0;

  logic CLOCK_50 = 1'b0;
  logic reset_data_N;

  midi_msg_parser_if bus();

  midi_msg_parser #(.CHANNEL(CH)) dut (
    .CLOCK_50    (CLOCK_50),
    .reset_data_N(reset_data_N),
    .midi        (bus)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int n_total = 0;
  int n_bad   = 0;

  // Model state: running status (-1 = none), sysex flag, collected data bytes.
  int         m_rs;
  bit         m_sysex;
  logic [7:0] m_dq[$];
  logic [4:0] m_stb;   // {note_on, note_off, cc, prog, pitch}
  logic [7:0] m_ictrl, m_data;
  logic [3:0] m_ch;
  int         m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_rs = -1; m_sysex = 0; m_dq.delete();
    m_stb = 0; m_ictrl = 0; m_data = 0; m_ch = 0; m_err = 0;
  endtask

  task automatic model_finish(input logic [7:0] st, input logic [7:0] a, input logic [7:0] b);
    bit ok;
`ifdef MIDI_OMNI_EN
    ok = 1;
`else
    ok = (st[3:0] == CH);
`endif
    if (!ok) return;
    case (st[7:4])
      4'h8: m_stb = 5'b01000;
      4'h9: m_stb = (b != 0) ? 5'b10000 : 5'b01000;
      4'hB: m_stb = 5'b00100;
      4'hC: m_stb = 5'b00010;
      4'hE: m_stb = 5'b00001;
      default: m_stb = 0;
    endcase
    if (m_stb != 0) begin
      m_ictrl = a; m_data = b; m_ch = st[3:0];
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    int need;
    logic [7:0] st;
    m_stb = 0;
    if (b >= 8'hF8) begin
    end else if (b == 8'hF0) begin
      m_sysex = 1; m_rs = -1; m_dq.delete();
    end else if (b >= 8'hF1) begin
      m_sysex = 0; m_rs = -1; m_dq.delete();
    end else if (b >= 8'h80) begin
      m_sysex = 0; m_rs = b; m_dq.delete();
    end else if (m_sysex) begin
    end else if (m_rs < 0) begin
      if (m_err < 255) m_err++;
    end else begin
      st = m_rs[7:0];
      need = (st[7:4] == 4'hC || st[7:4] == 4'hD) ? 1 : 2;
      m_dq.push_back(b);
      if (m_dq.size() == need) begin
        model_finish(st, m_dq[0], (need == 2) ? m_dq[1] : 8'h00);
        m_dq.delete();
      end
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".stb"}, {bus.note_on, bus.note_off, bus.cc_cmd, bus.prog_cmd, bus.pitch_cmd}, m_stb);
    chk({tag, ".ictrl"}, bus.ictrl, m_ictrl);
    chk({tag, ".ictrl_data"}, bus.ictrl_data, m_data);
    chk({tag, ".msg_ch"}, bus.msg_ch, m_ch);
    chk({tag, ".err_cnt"}, bus.err_cnt, m_err);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge CLOCK_50);
    bus.byte_valid = 1'b1;
    bus.midi_byte  = b;
    model_byte(b);
    @(posedge CLOCK_50);
    #1;
    bus.byte_valid = 1'b0;
    compare_all("byte");
  endtask

  task automatic idle_cycle();
    @(negedge CLOCK_50);
    bus.byte_valid = 1'b0;
    bus.midi_byte  = $urandom_range(0, 255);
    m_stb = 0;
    @(posedge CLOCK_50);
    #1;
    compare_all("idle");
  endtask

  task automatic do_reset();
    @(negedge CLOCK_50);
    bus.byte_valid = 1'b0;
    reset_data_N = 1'b0;
    model_reset();
    #1;
    compare_all("reset");
    @(negedge CLOCK_50);
    reset_data_N = 1'b1;
  endtask

  function automatic logic [7:0] rand_byte();
    int r;
    logic [2:0] k;
    logic [3:0] c;
    r = $urandom_range(0, 99);
    if (r < 55) return 8'($urandom_range(0, 127));
    if (r < 80) begin
      k = 3'($urandom_range(0, 6));
      c = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'(CH);
      return {1'b1, k, c};
    end
    if (r < 85) return 8'hF0;
    if (r < 90) return 8'hF7;
    if (r < 93) return 8'($urandom_range(8'hF1, 8'hF6));
    return 8'($urandom_range(8'hF8, 8'hFF));
  endfunction

  task automatic send_seq(input logic [7:0] s[$]);
    foreach (s[i]) send(s[i]);
  endtask

  initial begin
    bus.byte_valid = 1'b0;
    bus.midi_byte  = 8'h00;
    reset_data_N   = 1'b1;
    model_reset();
    do_reset();
    idle_cycle();

    // Pitch bend, centre value.
    send_seq('{8'hE0, 8'h00, 8'h40});
    idle_cycle();
    chk("bend_value", {18'd0, bus.ictrl_data[6:0], bus.ictrl[6:0]}, 32'd8192);

    // Running status with velocity-0 note-on.
    send_seq('{8'h90, 8'h3C, 8'h64, 8'h3E, 8'h64, 8'h3E, 8'h00});
    chk("vel0_off_key", bus.ictrl, 8'h3E);

    // Real-time byte inside a message.
    send_seq('{8'hB0, 8'h07, 8'hF8, 8'h7F});

    // Other-channel message.
    send_seq('{8'h91, 8'h3C, 8'h64});

    // SysEx then orphans, then a program change.
    send_seq('{8'hF0, 8'h7E, 8'h01, 8'hF7, 8'h3C, 8'h64});
    chk("sysex_orphans", bus.err_cnt, 8'd2);
    send_seq('{8'hC0, 8'h05});

    // Abort a partial note with a controller message.
    send_seq('{8'h90, 8'h3C, 8'hB0, 8'h01, 8'h02});

    // Reset mid-message; the following data bytes are orphans.
    send(8'hE0);
    do_reset();
    send_seq('{8'h00, 8'h40});
    chk("reset_orphans", bus.err_cnt, 8'd2);

    // Orphan counter saturation.
    for (int i = 0; i < 260; i++) send(8'h10);
    chk("err_saturate", bus.err_cnt, 8'd255);
    do_reset();

    // Random byte streams with gaps and the odd reset.
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = $urandom_range(0, 399);
      if (r == 0) do_reset();
      else if (r < 40) idle_cycle();
      else send(rand_byte());
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
